// File: rtl/reg_file_param.sv
// Parameterised two-read, one-write register file with registered read ports,
// optional hardwired-zero entry 0, optional write-first bypass and a bulk-clear sequencer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | normal operation: writes accepted, bypass active, i_clear armed
// S_CLEAR | sweeping mem[cnt] to zero, one entry per cycle; writes dropped
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_readAdd1,
  input  logic [ADDR_W-1:0] i_readAdd2,
  input  logic              i_readEn1,
  input  logic              i_readEn2,
  output logic [DATA_W-1:0] o_readData1,
  output logic [DATA_W-1:0] o_readData2,
  input  logic              i_writeEn,
  input  logic [ADDR_W-1:0] i_writeAdd,
  input  logic [DATA_W-1:0] i_writeData,
  input  logic              i_clear,
  output logic              o_busy,
  output logic              o_clearDone
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_readData1;
  logic [DATA_W-1:0]   r_readData2;
  logic                r_clearDone;
  logic                w_busy;
  logic                w_clear_last;
  logic                w_wr_ok;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // cnt is forced back to zero on the last entry rather than allowed to wrap
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (i_clear) begin
          w_state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + ADDR_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    w_busy       = (r_state == S_CLEAR);
    w_clear_last = w_busy && (r_cnt == LAST);
    w_wr_ok      = (r_state == S_IDLE) && i_writeEn &&
                   !((ZERO_REG != 0) && (i_writeAdd == '0));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      r_mem[i_writeAdd] <= i_writeData;
    end
  end

  // w_wr_ok already excludes CLEAR and a discarded write to entry 0
  always_comb begin
    if ((ZERO_REG != 0) && (i_readAdd1 == '0)) begin
      w_rd1 = '0;
    end else if ((BYPASS != 0) && w_wr_ok && (i_writeAdd == i_readAdd1)) begin
      w_rd1 = i_writeData;
    end else begin
      w_rd1 = r_mem[i_readAdd1];
    end
    if ((ZERO_REG != 0) && (i_readAdd2 == '0)) begin
      w_rd2 = '0;
    end else if ((BYPASS != 0) && w_wr_ok && (i_writeAdd == i_readAdd2)) begin
      w_rd2 = i_writeData;
    end else begin
      w_rd2 = r_mem[i_readAdd2];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_readData1 <= '0;
      r_readData2 <= '0;
      r_clearDone <= 1'b0;
    end else begin
      if (i_readEn1) begin
        r_readData1 <= w_rd1;
      end
      if (i_readEn2) begin
        r_readData2 <= w_rd2;
      end
      r_clearDone <= w_clear_last;
    end
  end

  assign o_readData1 = r_readData1;
  assign o_readData2 = r_readData2;
  assign o_busy      = w_busy;
  assign o_clearDone = r_clearDone;

endmodule
